// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side round-robin arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: lowest requester strictly above ptr, wrapping,
// found by priority-encoding a pointer-masked double-width copy of the request vector.
module rr_arb_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  win
);

  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] masked;
  int                hit;

  always_comb begin
    dbl    = {req, req};
    masked = '0;
    win    = '0;
    hit    = 0;
    for (int j = 0; j < 2*NREQ; j++) masked[j] = dbl[j] && (j > int'(ptr));
    for (int j = 2*NREQ-1; j >= 0; j--) begin
      if (masked[j]) hit = j;
    end
    if (|masked) win[hit % NREQ] = 1'b1;
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ requesters,
// with bounded bursts and a zero-latency, wfull-gated datapath.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 16,
  parameter int MAXBURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic [DSIZE-1:0]      fifo_wdata,
  output logic                  fifo_winc,
  input  logic                  fifo_wfull,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
);

  localparam int PTR_W = clog2(NREQ);
  localparam int CNT_W = clog2(MAXBURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAXBURST);
  localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(NREQ - 1);

  state_t           state, state_nxt;
  logic [NREQ-1:0]  grant_nxt, win;
  logic [CNT_W-1:0] beat_cnt, beat_nxt, beat_inc;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt, owner_idx;
  logic             owner_valid, owner_last, release_now;
  logic [DSIZE-1:0] wdata_mux;

  rr_arb_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .win (win)
  );

  assign owner_valid = |(req_valid & grant);
  assign owner_last  = |(req_last & grant);
  assign beat_inc    = beat_cnt + 1'b1;
  // Gating on wfull mirrors the FIFO's own winc & ~wfull, so every accepted word lands.
  assign req_ready   = (state == GRANT && !fifo_wfull && !rst) ? (req_valid & grant) : '0;
  assign fifo_winc   = |(req_valid & req_ready);
  assign busy        = (state == GRANT);

  always_comb begin
    wdata_mux = '0;
    owner_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        wdata_mux = wdata_mux | req_data[i*DSIZE +: DSIZE];
        owner_idx = PTR_W'(i);
      end
    end
  end

  assign fifo_wdata = wdata_mux;

  // A stalled FIFO holds the grant even if the owner drops valid.
  assign release_now = (fifo_winc && (owner_last || beat_inc == BURST_MAX)) ||
                       (!owner_valid && !fifo_wfull);

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    beat_nxt   = beat_cnt;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_nxt = GRANT;
          grant_nxt = win;
          beat_nxt  = '0;
        end
      end
      GRANT: begin
        if (fifo_winc) beat_nxt = beat_inc;
        if (release_now) begin
          state_nxt  = IDLE;
          grant_nxt  = '0;
          beat_nxt   = '0;
          rr_ptr_nxt = owner_idx;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      beat_cnt <= '0;
      rr_ptr   <= PTR_RST;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      beat_cnt <= beat_nxt;
      rr_ptr   <= rr_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: per-requester word queues feed the DUT; a transaction-level
// owner/burst model predicts grant, ready, winc and wdata every cycle.
module tb_fifo_wr_arb;

  localparam int NREQ     = 4;
  localparam int DSIZE    = 16;
  localparam int MAXBURST = 4;
  localparam int QDEPTH   = 1024;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic [DSIZE-1:0]      fifo_wdata;
  logic                  fifo_winc;
  logic                  fifo_wfull;
  logic [NREQ-1:0]       grant;
  logic                  busy;

  fifo_wr_arb #(
    .NREQ     (NREQ),
    .DSIZE    (DSIZE),
    .MAXBURST (MAXBURST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_wdata (fifo_wdata),
    .fifo_winc  (fifo_winc),
    .fifo_wfull (fifo_wfull),
    .grant      (grant),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  logic [DSIZE:0]  mem [NREQ][QDEPTH];
  int              head [NREQ];
  int              tail [NREQ];
  logic [NREQ-1:0] en;

  // Reference model: current owner (-1 when nobody holds the port), words moved
  // in this grant, and the requester that owned the port most recently.
  int owner;
  int beats;
  int last_owner;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [DSIZE-1:0] d, input logic l);
    if (tail[i] < QDEPTH) begin
      mem[i][tail[i]] = {l, d};
      tail[i]++;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (en[i] && head[i] < tail[i]) begin
        req_valid[i]                = 1'b1;
        req_data[i*DSIZE +: DSIZE]  = mem[i][head[i]][DSIZE-1:0];
        req_last[i]                 = mem[i][head[i]][DSIZE];
      end else begin
        req_valid[i]                = 1'b0;
        req_data[i*DSIZE +: DSIZE]  = '0;
        req_last[i]                 = 1'b0;
      end
    end
  endtask

  task automatic release_owner();
    last_owner = owner;
    owner      = -1;
    beats      = 0;
  endtask

  // One clock: present inputs, compare outputs, then advance the model at the edge.
  task automatic step();
    logic [NREQ-1:0]  er;
    logic [DSIZE-1:0] ed;
    logic [NREQ-1:0]  eg;
    bit               found;
    int               cand;
    bit               was_last;
    drive();
    #1;
    er = '0;
    eg = '0;
    ed = '0;
    if (owner >= 0) begin
      eg[owner] = 1'b1;
      ed        = req_data[owner*DSIZE +: DSIZE];
      if (!rst && !fifo_wfull && req_valid[owner]) er[owner] = 1'b1;
    end
    check("grant",      32'(grant),      32'(eg));
    check("busy",       32'(busy),       32'(owner >= 0));
    check("req_ready",  32'(req_ready),  32'(er));
    check("fifo_winc",  32'(fifo_winc),  32'(|er));
    check("fifo_wdata", 32'(fifo_wdata), 32'(ed));
    if (fifo_winc === 1'b1) wr_cnt++;
    @(posedge clk);
    if (rst) begin
      owner      = -1;
      beats      = 0;
      last_owner = NREQ - 1;
    end else if (owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        cand = (last_owner + k) % NREQ;
        if (!found && req_valid[cand]) begin
          found = 1'b1;
          owner = cand;
          beats = 0;
        end
      end
    end else if (!fifo_wfull) begin
      if (!req_valid[owner]) begin
        release_owner();
      end else begin
        was_last = mem[owner][head[owner]][DSIZE];
        head[owner]++;
        beats++;
        if (was_last || beats == MAXBURST) release_owner();
      end
    end
    #1;
  endtask

  initial begin
    int w0;
    rst        = 1'b1;
    fifo_wfull = 1'b0;
    en         = '1;
    owner      = -1;
    beats      = 0;
    last_owner = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    drive();
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;

    // Single requester, six words, no last: burst of 4, bubble, regrant for 2.
    for (int n = 0; n < 6; n++) push(0, DSIZE'(16'hA000 + n), 1'b0);
    w0 = wr_cnt;
    repeat (12) step();
    check("burst_words", 32'(wr_cnt - w0), 32'd6);

    // All four streaming two-word packets, starting from reset: order 0,1,2,3,...
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++)
      for (int n = 0; n < 4; n++) push(i, DSIZE'(16'hB000 + i*16 + n), n[0]);
    w0 = wr_cnt;
    step();
    check("first_grant_rr", 32'(grant), 32'h1);
    repeat (23) step();
    check("rr_duty_words", 32'(wr_cnt - w0), 32'd16);
    repeat (4) step();

    // Requester 2 stalled by a full FIFO for five cycles mid-burst.
    for (int n = 0; n < 4; n++) push(2, DSIZE'(16'hC000 + n), 1'b0);
    repeat (2) step();
    fifo_wfull = 1'b1;
    w0 = wr_cnt;
    repeat (5) step();
    check("stall_no_writes", 32'(wr_cnt - w0), 32'd0);
    check("stall_grant_kept", 32'(grant), 32'h4);
    fifo_wfull = 1'b0;
    repeat (6) step();

    // Requester 1 goes idle after one word; next arbitration favours requester 2.
    push(1, 16'hD000, 1'b0);
    repeat (3) step();
    push(1, 16'hD001, 1'b1);
    push(2, 16'hD002, 1'b1);
    step();
    check("after_drop_grant", 32'(grant), 32'h4);
    repeat (6) step();

    // Reset in the middle of a burst from requester 3.
    for (int n = 0; n < 6; n++) push(3, DSIZE'(16'hE000 + n), 1'b0);
    repeat (3) step();
    for (int i = 0; i < 3; i++) push(i, DSIZE'(16'hE100 + i), 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("post_rst_grant", 32'(grant), 32'h0);
    check("post_rst_busy",  32'(busy),  32'h0);
    step();
    check("post_rst_winner", 32'(grant), 32'h1);
    repeat (20) step();

    // Randomised traffic: valid drops, FIFO back-pressure, random packet ends, rare resets.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        en[i] = ($urandom_range(0, 7) != 0);
        if (tail[i] - head[i] < 4 && $urandom_range(0, 1) == 1)
          push(i, DSIZE'($urandom), ($urandom_range(0, 2) == 0));
      end
      fifo_wfull = ($urandom_range(0, 3) == 0);
      rst        = ($urandom_range(0, 99) == 0);
      step();
    end
    rst        = 1'b0;
    fifo_wfull = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write-side arbiter that shares the single write port of the async FIFO (`fifo1`) among NREQ requesters in the write clock domain. Each requester presents words with a valid/ready handshake and optional end-of-packet marker. The arbiter grants one requester at a time for a bounded burst and forwards its words to the FIFO, stalling on `wfull` so no word is dropped. It sits between the producer-side engines and the FIFO `wdata`/`winc`/`wfull` pins.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `DSIZE`, default 16: data word width; must equal the FIFO `DSIZE`.
- `MAXBURST`, default 4: maximum words per grant, ≥1.
- `clk` in 1: write-domain clock, the same net as the FIFO `wclk`.
- `rst` in 1: synchronous active-high reset; one clock, and reset is synchronous and active-high.
- `req_valid` in NREQ: requester i has a word.
- `req_data` in NREQ*DSIZE: word of requester i at bits [i*DSIZE +: DSIZE].
- `req_last` in NREQ: the word of requester i is last of packet.
- `req_ready` out NREQ: the word of requester i is accepted this cycle.
- `fifo_wdata` out DSIZE: to FIFO `wdata`.
- `fifo_winc` out 1: to FIFO `winc`.
- `fifo_wfull` in 1: from FIFO `wfull`.
- `grant` out NREQ: one-hot current owner, registered.
- `busy` out 1: high in GRANT state.

## Operation
- FSM states: IDLE, GRANT.
- IDLE:
  - If `req_valid` is nonzero, select a winner with the round-robin picker, searching from `rr_ptr+1` upward, modulo NREQ.
  - Register the one-hot winner into `grant`, clear `beat_cnt`, and go to GRANT.
  - Otherwise stay in IDLE with `grant` = 0.
- GRANT, owner g:
  - `req_ready[g]` = `req_valid[g]` & !`fifo_wfull` & !`rst`; all other bits of `req_ready` are 0.
  - `fifo_winc` = OR of (`req_valid` & `req_ready`).
  - `fifo_wdata` = `req_data` slice of g. It is a mux on the registered `grant`, and outputs 0 when `grant` = 0.
  - On each transfer, `beat_cnt` increments. The counter is clog2(MAXBURST+1) bits wide, with no wrap.
- Release from GRANT to IDLE occurs at the clock edge after any of these:
  - a transfer with `req_last[g]`=1;
  - a transfer that makes `beat_cnt` = MAXBURST;
  - `req_valid[g]`=0 while `fifo_wfull`=0, i.e. the owner went idle.
- On release, `rr_ptr` is set to g, and `grant` and `beat_cnt` clear.
- `fifo_wfull`=1 during GRANT:
  - No transfer occurs and `beat_cnt` holds.
  - The grant is held regardless of `req_valid[g]`.
- Requesters must hold `req_valid`, `req_data` and `req_last` stable until ready. Dropping valid without ready is legal; it releases the grant.
- A requester that is not granted sees ready=0. There is no starvation: every requester is served within NREQ grants.

## Timing
- Reset values:
  - state IDLE, `grant` 0, `busy` 0, `beat_cnt` 0, `rr_ptr` NREQ-1, so requester 0 wins first.
  - Combinational outputs: `req_ready` 0, `fifo_winc` 0, `fifo_wdata` 0.
- Arbitration latency:
  - `req_valid` rising in IDLE at cycle t gives `grant`/`busy` at t+1.
  - The first transfer can occur at t+1 if the FIFO is not full.
- Throughput: one word per clock within a grant.
- Grant overhead: one IDLE bubble cycle between consecutive grants.
- The datapath is zero-latency: `fifo_winc`/`fifo_wdata` are combinational from `req_valid`, `grant` and `fifo_wfull`.
- `fifo_wfull` is a registered FIFO output that reflects the previous write. Gating ready on it matches the FIFO's internal `winc & ~wfull`, so every accepted word is written.
- Reset asserted mid-burst: `rst` forces `req_ready`/`fifo_winc` to 0 in that cycle, so no partial write. The next edge returns all state to reset values. The FIFO is reset separately.
- Simultaneous last and MAXBURST on one transfer: a single release.
- Simultaneous requests in IDLE: the winner is the nearest index above `rr_ptr`.

## Structure
- Package `fifo_arb_pkg`:
  - state enum {IDLE, GRANT};
  - `clog2` function for the `beat_cnt` width.
- Sub-module `rr_arb_pick` (combinational):
  - inputs `req[NREQ]` and `ptr`; output one-hot `win[NREQ]`;
  - implemented with a double-width masked priority encode.
- Top level: FSM, `beat_cnt`, `rr_ptr`, handshake gating and data mux.

## Test plan
- Reset, then `req_valid`=4'b0001 with words 0xA000..0xA005 and no last:
  - `grant`=0001 at the cycle after valid;
  - 4 `fifo_winc` pulses with 0xA000..0xA003;
  - release, one bubble, regrant, then 0xA004 and 0xA005.
- All four valid continuously, each with `req_last` on its 2nd word:
  - grant order 0,1,2,3,0;
  - exactly 2 words per grant;
  - `fifo_winc` duty is 2 of every 3 cycles.
- Requester 2 granted and `fifo_wfull`=1 for 5 cycles mid-burst:
  - `req_ready`=0 and `fifo_winc`=0 throughout;
  - `beat_cnt` holds;
  - the grant is kept, then resumes with the same word.
- Requester 1 drops valid after 1 word with `fifo_wfull`=0:
  - release at the next edge;
  - `rr_ptr`=1, so the next grant goes to 2 when requesters 1 and 2 are both valid.
- `rst` pulsed for 1 cycle during a burst from requester 3:
  - `fifo_winc`=0 in the reset cycle;
  - then `grant`=0 and `busy`=0;
  - the next arbitration picks requester 0 when all are valid.
